// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM responder: command encodings, error causes and
// mode-register field positions.
package sdram_pkg;

   typedef enum logic [2:0] {
      CMD_LOAD_MODE    = 3'b000,
      CMD_AUTO_REFRESH = 3'b001,
      CMD_PRECHARGE    = 3'b010,
      CMD_ACTIVE       = 3'b011,
      CMD_WRITE        = 3'b100,
      CMD_READ         = 3'b101,
      CMD_BURST_TERM   = 3'b110,
      CMD_NOP          = 3'b111
   } cmd_t;

   typedef enum logic [2:0] {
      ERR_NONE         = 3'd0,
      ERR_MODE_OPEN    = 3'd1,
      ERR_BAD_MODE     = 3'd2,
      ERR_DOUBLE_ACT   = 3'd3,
      ERR_CLOSED_BANK  = 3'd4,
      ERR_REFRESH_OPEN = 3'd5,
      ERR_TIMING       = 3'd6
   } err_t;

   localparam int MODE_BL_LSB = 0;
   localparam int MODE_BL_MSB = 2;
   localparam int MODE_CL_LSB = 4;
   localparam int MODE_CL_MSB = 6;
   localparam int ADDR_AP_BIT = 10;

   // A deselected chip always decodes as NOP regardless of the strobes.
   function automatic cmd_t decode_cmd(input logic ncs, input logic nras,
                                       input logic ncas, input logic nwe);
      if (ncs) return CMD_NOP;
      return cmd_t'({nras, ncas, nwe});
   endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// SDRAM pin bundle between the controller (master) and the responder (slave).
interface sdram_responder_if;
   import sdram_pkg::*;

   logic        sdram_ncs;
   logic        sdram_nras;
   logic        sdram_ncas;
   logic        sdram_nwe;
   logic [12:0] sdram_a;
   logic [1:0]  sdram_ba;
   logic        sdram_dqml;
   logic        sdram_dqmh;
   logic [15:0] dq_in;
   logic [15:0] dq_out;
   logic        dq_oe;

   // Commands carry no ready: each one is consumed on the edge it is sampled.
   // dq_oe is the valid for dq_out, high for exactly one cycle per read.
   modport master (
      output sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_a, sdram_ba,
      output sdram_dqml, sdram_dqmh, dq_in,
      input  dq_out, dq_oe
   );

   modport slave (
      input  sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_a, sdram_ba,
      input  sdram_dqml, sdram_dqmh, dq_in,
      output dq_out, dq_oe
   );

endinterface

// File: rtl/sdram_resp_mem.sv
// Two-lane byte-enable single-port RAM with a registered one-cycle read.
module sdram_resp_mem
   import sdram_pkg::*;
#(
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [1:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [7:0] lane_lo [2**AW];
   logic [7:0] lane_hi [2**AW];

   // rdata holds across write cycles so an in-flight read is never disturbed.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            if (be[0]) lane_lo[addr] <= wdata[7:0];
            if (be[1]) lane_hi[addr] <= wdata[15:8];
         end else begin
            rdata <= {lane_hi[addr], lane_lo[addr]};
         end
      end
   end

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator: command decode, per-bank open rows, CAS-latency
// read pipeline and sticky protocol errors. Optional SDRAM_TIMING_CHECK_EN adds tRCD/tRP/tRFC checks.
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 9,
   parameter int TRCD     = 2,
   parameter int TRP      = 2,
   parameter int TRFC     = 7
) (
   input  logic               clk,
   input  logic               init,
   sdram_responder_if.slave   bus,
   output logic [1:0]         cas_lat,
   output logic [15:0]        refresh_cnt,
   output logic               err,
   output logic [2:0]         err_code
);

   localparam int AW = 2 + ROW_BITS + COL_BITS;

   cmd_t                cmd;
   err_t                cmd_err;
   logic [1:0]          ba;
   logic [3:0]          bank_open;
   logic [ROW_BITS-1:0] open_row [4];
   logic                any_open;
   logic                auto_pre;
   logic [2:0]          cl_field;
   logic                cl_ok;
   logic                rd_go, wr_go;
   logic                tim_viol;
   logic [AW-1:0]       mem_addr;
   logic [15:0]         rdata, rd_masked;
   logic                s1_valid, s1_cl3, s2_valid;
   logic [1:0]          s1_mask;
   logic [15:0]         s2_data, dq_out_q;
   logic                dq_oe_q;
   logic                unused_ok;

   assign cmd      = decode_cmd(bus.sdram_ncs, bus.sdram_nras, bus.sdram_ncas, bus.sdram_nwe);
   assign ba       = bus.sdram_ba;
   assign any_open = |bank_open;
   assign auto_pre = bus.sdram_a[ADDR_AP_BIT];
   assign cl_field = bus.sdram_a[MODE_CL_MSB:MODE_CL_LSB];
   assign cl_ok    = (cl_field == 3'd2) || (cl_field == 3'd3);

   always_comb begin
      cmd_err = ERR_NONE;
      rd_go   = 1'b0;
      wr_go   = 1'b0;
      case (cmd)
         CMD_LOAD_MODE: begin
            if (any_open) cmd_err = ERR_MODE_OPEN;
            else if (!cl_ok || bus.sdram_a[MODE_BL_MSB:MODE_BL_LSB] != 3'b000)
               cmd_err = ERR_BAD_MODE;
         end
         CMD_ACTIVE:       if (bank_open[ba]) cmd_err = ERR_DOUBLE_ACT;
         CMD_READ:         if (!bank_open[ba]) cmd_err = ERR_CLOSED_BANK; else rd_go = 1'b1;
         CMD_WRITE:        if (!bank_open[ba]) cmd_err = ERR_CLOSED_BANK; else wr_go = 1'b1;
         CMD_AUTO_REFRESH: if (any_open) cmd_err = ERR_REFRESH_OPEN;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         bank_open   <= 4'b0000;
         cas_lat     <= 2'd2;
         refresh_cnt <= 16'd0;
         err         <= 1'b0;
         err_code    <= 3'd0;
      end else begin
         case (cmd)
            CMD_LOAD_MODE:    if (!any_open && cl_ok) cas_lat <= cl_field[1:0];
            CMD_ACTIVE:       if (!bank_open[ba]) bank_open[ba] <= 1'b1;
            CMD_READ,
            CMD_WRITE:        if (bank_open[ba] && auto_pre) bank_open[ba] <= 1'b0;
            CMD_PRECHARGE:    if (auto_pre) bank_open <= 4'b0000; else bank_open[ba] <= 1'b0;
            CMD_AUTO_REFRESH: refresh_cnt <= refresh_cnt + 16'd1;
            default: ;
         endcase
         // First cause wins; a functional error outranks a same-cycle timing one.
         if (!err && (cmd_err != ERR_NONE || tim_viol)) begin
            err      <= 1'b1;
            err_code <= (cmd_err != ERR_NONE) ? cmd_err : ERR_TIMING;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cmd == CMD_ACTIVE && !bank_open[ba])
         open_row[ba] <= bus.sdram_a[ROW_BITS-1:0];
   end

   assign mem_addr = {ba, open_row[ba], bus.sdram_a[COL_BITS-1:0]};

   sdram_resp_mem #(.AW(AW)) u_mem (
      .clk   (clk),
      .en    (rd_go | wr_go),
      .we    (wr_go),
      .be    (~{bus.sdram_dqmh, bus.sdram_dqml}),
      .addr  (mem_addr),
      .wdata (bus.dq_in),
      .rdata (rdata)
   );

   assign rd_masked = {s1_mask[1] ? 8'h00 : rdata[15:8], s1_mask[0] ? 8'h00 : rdata[7:0]};

   // Latency is captured per read, so a later mode change never retimes it.
   always_ff @(posedge clk) begin
      if (init) begin
         s1_valid <= 1'b0;
         s1_cl3   <= 1'b0;
         s1_mask  <= 2'b00;
         s2_valid <= 1'b0;
         s2_data  <= 16'h0000;
         dq_out_q <= 16'h0000;
         dq_oe_q  <= 1'b0;
      end else begin
         s1_valid <= rd_go;
         s1_cl3   <= (cas_lat == 2'd3);
         s1_mask  <= {bus.sdram_dqmh, bus.sdram_dqml};
         s2_valid <= s1_valid & s1_cl3;
         s2_data  <= rd_masked;
         if (s2_valid) begin
            dq_out_q <= s2_data;
            dq_oe_q  <= 1'b1;
         end else if (s1_valid && !s1_cl3) begin
            dq_out_q <= rd_masked;
            dq_oe_q  <= 1'b1;
         end else begin
            dq_out_q <= 16'h0000;
            dq_oe_q  <= 1'b0;
         end
      end
   end

   assign bus.dq_out = dq_out_q;
   assign bus.dq_oe  = dq_oe_q;

`ifdef SDRAM_TIMING_CHECK_EN
   localparam logic [7:0] TRCD_LD = 8'((TRCD > 0) ? TRCD - 1 : 0);
   localparam logic [7:0] TRP_LD  = 8'((TRP  > 0) ? TRP  - 1 : 0);
   localparam logic [7:0] TRFC_LD = 8'((TRFC > 0) ? TRFC - 1 : 0);

   logic [7:0] trcd_cnt [4];
   logic [7:0] trp_cnt  [4];
   logic [7:0] trfc_cnt;

   always_comb begin
      tim_viol = 1'b0;
      if (cmd != CMD_NOP && trfc_cnt != 8'd0) tim_viol = 1'b1;
      if ((cmd == CMD_READ || cmd == CMD_WRITE) && trcd_cnt[ba] != 8'd0) tim_viol = 1'b1;
      if (cmd == CMD_ACTIVE && trp_cnt[ba] != 8'd0) tim_viol = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (init) begin
         for (int b = 0; b < 4; b++) begin
            trcd_cnt[b] <= 8'd0;
            trp_cnt[b]  <= 8'd0;
         end
         trfc_cnt <= 8'd0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (trcd_cnt[b] != 8'd0) trcd_cnt[b] <= trcd_cnt[b] - 8'd1;
            if (trp_cnt[b]  != 8'd0) trp_cnt[b]  <= trp_cnt[b]  - 8'd1;
         end
         if (trfc_cnt != 8'd0) trfc_cnt <= trfc_cnt - 8'd1;
         case (cmd)
            CMD_ACTIVE:       if (!bank_open[ba]) trcd_cnt[ba] <= TRCD_LD;
            CMD_READ,
            CMD_WRITE:        if (bank_open[ba] && auto_pre) trp_cnt[ba] <= TRP_LD;
            CMD_PRECHARGE: begin
               if (auto_pre) for (int b = 0; b < 4; b++) trp_cnt[b] <= TRP_LD;
               else trp_cnt[ba] <= TRP_LD;
            end
            CMD_AUTO_REFRESH: trfc_cnt <= TRFC_LD;
            default: ;
         endcase
      end
   end

   assign unused_ok = ^bus.sdram_a;
`else
   assign tim_viol  = 1'b0;
   assign unused_ok = ^{bus.sdram_a, TRCD, TRP, TRFC};
`endif

endmodule
